// File: rtl/gpio_in_cond_pkg.sv
// Shared constants for the GPIO input conditioner: register map and bus width.
// Register reads and writes use an 8-bit data path on a 2-bit address.
package gpio_pkg;

    localparam int BUS_W  = 8;
    localparam int ADR_W  = 2;

    localparam logic [ADR_W-1:0] ADR_PEND    = 2'd0;
    localparam logic [ADR_W-1:0] ADR_RISE_EN = 2'd1;
    localparam logic [ADR_W-1:0] ADR_FALL_EN = 2'd2;
    localparam logic [ADR_W-1:0] ADR_LEVEL   = 2'd3;

    // Register-bank decode of one bus access, resolved once in the top.
    typedef struct packed {
        logic req;
        logic wr;
        logic wr_pend;
        logic wr_rise_en;
        logic wr_fall_en;
    } bus_dec_t;

    function automatic bus_dec_t decode_access(
        input logic             cyc,
        input logic             stb,
        input logic             we,
        input logic             ack,
        input logic [ADR_W-1:0] adr
    );
        bus_dec_t d;
        d            = '0;
        d.req        = cyc & stb & ~ack;
        d.wr         = d.req & we;
        d.wr_pend    = d.wr & (adr == ADR_PEND);
        d.wr_rise_en = d.wr & (adr == ADR_RISE_EN);
        d.wr_fall_en = d.wr & (adr == ADR_FALL_EN);
        return d;
    endfunction

endpackage

// File: rtl/gpio_in_cond_if.sv
// Wishbone slave bus bundle for the input conditioner's register port.
// The CPU side uses master, the conditioner uses slave.
interface gpio_in_cond_if;
    import gpio_pkg::*;

    logic [ADR_W-1:0] wb_adr_i;
    logic [BUS_W-1:0] wb_dat_i;
    logic             wb_we_i;
    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic [BUS_W-1:0] wb_dat_o;
    logic             wb_ack_o;
    logic             wb_err_o;
    logic             wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

endinterface

// File: rtl/gpio_debounce_bit.sv
// One pin: two-flop synchroniser, sample counter and debounced level flop.
// The level only flips after DB_SAMPLES consecutive ticks that disagree with it.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int DB_SAMPLES = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic tick,
    input  logic pad,
    output logic clean
);

    localparam int CNT_W = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_SAMPLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             clean_q, clean_d;

    always_comb begin
        sync1_d = pad;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (tick) begin
            if (sync2_q != clean_q) begin
                // The last disagreeing sample flips the level and restarts the count.
                if (cnt_q == CNT_LAST) begin
                    clean_d = ~clean_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: per-pin debounce, edge detection into a sticky W1C
// pending register, an interrupt line, and a small Wishbone register port.
module gpio_in_cond
    import gpio_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 1000,
    parameter int DB_SAMPLES = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    gpio_in_cond_if.slave     wb,
    input  logic [WIDTH-1:0]  pad_i,
    output logic [WIDTH-1:0]  gpio_clean_o,
    output logic              irq_o
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  ps_q, ps_d;
    logic             tick;

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_dly_q, level_dly_d;
    logic [WIDTH-1:0] rise, fall, set;

    logic [WIDTH-1:0] pend_q,    pend_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic             irq_q,     irq_d;
    logic [BUS_W-1:0] dat_q,     dat_d;
    logic             ack_q,     ack_d;

    bus_dec_t         dec;
    logic [BUS_W-1:0] rd_mux;

    // Sample tick shared by every pin so all debouncers see the same time base.
    always_comb begin
        tick = (ps_q == PS_LAST);
        ps_d = tick ? '0 : ps_q + PS_W'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_db
            gpio_debounce_bit #(
                .DB_SAMPLES (DB_SAMPLES)
            ) u_db (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .tick      (tick),
                .pad       (pad_i[gi]),
                .clean     (level[gi])
            );
        end
    endgenerate

    always_comb begin
        level_dly_d = level;
        rise        = level & ~level_dly_q;
        fall        = ~level & level_dly_q;
        set         = (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_comb begin
        dec = decode_access(wb.wb_cyc_i, wb.wb_stb_i, wb.wb_we_i, ack_q, wb.wb_adr_i);

        rd_mux = '0;
        case (wb.wb_adr_i)
            ADR_PEND:    rd_mux = BUS_W'(pend_q);
            ADR_RISE_EN: rd_mux = BUS_W'(rise_en_q);
            ADR_FALL_EN: rd_mux = BUS_W'(fall_en_q);
            ADR_LEVEL:   rd_mux = BUS_W'(level);
            default:     rd_mux = '0;
        endcase

        pend_d    = pend_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (dec.wr_pend)    pend_d    = pend_q & ~wb.wb_dat_i[WIDTH-1:0];
        if (dec.wr_rise_en) rise_en_d = wb.wb_dat_i[WIDTH-1:0];
        if (dec.wr_fall_en) fall_en_d = wb.wb_dat_i[WIDTH-1:0];
        // OR-ing set in last lets a fresh edge survive a same-cycle W1C.
        pend_d = pend_d | set;

        irq_d = |pend_d;
        ack_d = dec.req;
        dat_d = dec.req ? rd_mux : dat_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ps_q        <= '0;
            level_dly_q <= '0;
            pend_q      <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            irq_q       <= 1'b0;
            dat_q       <= '0;
            ack_q       <= 1'b0;
        end else begin
            ps_q        <= ps_d;
            level_dly_q <= level_dly_d;
            pend_q      <= pend_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            irq_q       <= irq_d;
            dat_q       <= dat_d;
            ack_q       <= ack_d;
        end
    end

    assign gpio_clean_o = level;
    assign irq_o        = irq_q;
    assign wb.wb_dat_o  = dat_q;
    assign wb.wb_ack_o  = ack_q;
    assign wb.wb_err_o  = 1'b0;
    assign wb.wb_rty_o  = 1'b0;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed bench for gpio_in_cond with PRESCALE=4, DB_SAMPLES=3: a register
// access table plus hand-timed sequences for debounce, edges, W1C and reset.
module tb_gpio_in_cond;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pads;
    logic [7:0] gpio_clean;
    logic       irq;

    int checks = 0;
    int errors = 0;

    gpio_in_cond_if wbif ();

    gpio_in_cond #(
        .WIDTH      (8),
        .PRESCALE   (4),
        .DB_SAMPLES (3)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .wb           (wbif.slave),
        .pad_i        (pads),
        .gpio_clean_o (gpio_clean),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       we;
        logic [1:0] adr;
        logic [7:0] wdat;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_start(input logic we, input logic [1:0] adr, input logic [7:0] wdat);
        wbif.wb_cyc_i = 1'b1;
        wbif.wb_stb_i = 1'b1;
        wbif.wb_we_i  = we;
        wbif.wb_adr_i = adr;
        wbif.wb_dat_i = wdat;
    endtask

    // Waits for ack with a cycle budget; the ack must arrive on the first edge.
    task automatic wb_wait_ack(output logic [7:0] rdat);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n++;
            if (wbif.wb_ack_o === 1'b1) break;
        end
        check("ack_latency", n, 1);
        rdat = wbif.wb_dat_o;
        $display("wb we=%0b adr=%0d wdat=0x%02h rdat=0x%02h cycles=%0d",
                 wbif.wb_we_i, wbif.wb_adr_i, wbif.wb_dat_i, rdat, n);
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_stb_i = 1'b0;
        wbif.wb_we_i  = 1'b0;
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [7:0] wdat,
                           output logic [7:0] rdat);
        wb_start(we, adr, wdat);
        wb_wait_ack(rdat);
        @(negedge clk);
    endtask

    task automatic wait_level(input int b, input logic v, input int max_cyc, output int n);
        n = 0;
        while (n < max_cyc && gpio_clean[b] !== v) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dat_o"}, wbif.wb_dat_o, 0);
        check({tag, "_ack_o"}, wbif.wb_ack_o, 0);
        check({tag, "_irq"},   irq, 0);
        check({tag, "_clean"}, gpio_clean, 0);
        check({tag, "_err_rty"}, {wbif.wb_err_o, wbif.wb_rty_o}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         n;
        logic       seen;

        tbl[0] = '{"wr_rise_en",  1'b1, 2'd1, 8'h5A, 8'h00};
        tbl[1] = '{"rd_rise_en",  1'b0, 2'd1, 8'h00, 8'h5A};
        tbl[2] = '{"wr_fall_en",  1'b1, 2'd2, 8'hC3, 8'h00};
        tbl[3] = '{"rd_fall_en",  1'b0, 2'd2, 8'h00, 8'hC3};
        tbl[4] = '{"rd_level",    1'b0, 2'd3, 8'h00, 8'h01};
        tbl[5] = '{"clr_rise_en", 1'b1, 2'd1, 8'h00, 8'h5A};
        tbl[6] = '{"clr_fall_en", 1'b1, 2'd2, 8'h00, 8'hC3};
        tbl[7] = '{"rd_pend",     1'b0, 2'd0, 8'h00, 8'h00};

        rst_n         = 1'b0;
        pads          = 8'h00;
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_stb_i = 1'b0;
        wbif.wb_we_i  = 1'b0;
        wbif.wb_adr_i = 2'd0;
        wbif.wb_dat_i = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Pin high with enables cleared: level follows, nothing latched.
        pads[0] = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (irq) seen = 1'b1;
            if (n == 0 && gpio_clean[0]) n = c;
        end
        checks++;
        if (n == 0 || n > 17) begin
            errors++;
            $display("FAIL t1_clean_latency: got %0d cycles, expected 1..17", n);
        end
        check("t1_irq_quiet", seen, 0);

        for (int i = 0; i < 8; i++) begin
            wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].wdat, rd);
            check(tbl[i].name, rd, tbl[i].exp_dat);
        end

        // Rising edge latched, then cleared with W1C.
        wb_xfer(1'b1, 2'd1, 8'h01, rd);
        pads[0] = 1'b0;
        wait_level(0, 1'b0, 30, n);
        check("t2_fall_seen", gpio_clean[0], 0);
        pads[0] = 1'b1;
        wait_level(0, 1'b1, 30, n);
        check("t2_rise_seen", gpio_clean[0], 1);
        check("t2_irq_before", irq, 0);
        @(negedge clk);
        check("t2_irq_after_edge", irq, 1);
        wb_xfer(1'b0, 2'd0, 8'h00, rd);
        check("t2_pend_set", rd, 8'h01);
        wb_start(1'b1, 2'd0, 8'h01);
        wb_wait_ack(rd);
        check("t2_irq_cleared", irq, 0);
        @(negedge clk);
        wb_xfer(1'b0, 2'd0, 8'h00, rd);
        check("t2_pend_cleared", rd, 8'h00);

        // One-tick glitches on pin 3 never pass the debouncer.
        wb_xfer(1'b1, 2'd1, 8'h08, rd);
        seen = 1'b0;
        for (int r = 0; r < 6; r++) begin
            pads[3] = 1'b1;
            repeat (4) begin @(negedge clk); if (gpio_clean[3]) seen = 1'b1; end
            pads[3] = 1'b0;
            repeat (4) begin @(negedge clk); if (gpio_clean[3]) seen = 1'b1; end
        end
        repeat (12) begin @(negedge clk); if (gpio_clean[3]) seen = 1'b1; end
        check("t3_glitch_level", seen, 0);
        wb_xfer(1'b0, 2'd0, 8'h00, rd);
        check("t3_glitch_pend", rd, 8'h00);

        // Falling edge on pin 7 coincides with a W1C of the same bit.
        wb_xfer(1'b1, 2'd1, 8'h00, rd);
        pads[7] = 1'b1;
        wait_level(7, 1'b1, 30, n);
        check("t4_pin7_high", gpio_clean[7], 1);
        wb_xfer(1'b1, 2'd2, 8'h80, rd);
        pads[7] = 1'b0;
        wait_level(7, 1'b0, 30, n);
        check("t4_pin7_low", gpio_clean[7], 0);
        wb_start(1'b1, 2'd0, 8'h80);
        wb_wait_ack(rd);
        check("t4_irq_set_wins", irq, 1);
        @(negedge clk);
        wb_xfer(1'b0, 2'd0, 8'h00, rd);
        check("t4_pend_set_wins", rd, 8'h80);
        wb_xfer(1'b1, 2'd0, 8'h80, rd);
        check("t4_irq_final_clear", irq, 0);

        // Level read with exact ack timing, back-to-back acks, RO level.
        wb_xfer(1'b1, 2'd2, 8'h00, rd);
        pads = 8'hA5;
        repeat (30) @(negedge clk);
        check("t5_level_pins", gpio_clean, 8'hA5);
        wb_start(1'b0, 2'd3, 8'h00);
        check("t5_ack_before_edge", wbif.wb_ack_o, 0);
        @(negedge clk);
        check("t5_ack_cycle1", wbif.wb_ack_o, 1);
        check("t5_level_read", wbif.wb_dat_o, 8'hA5);
        @(negedge clk);
        check("t5_ack_cycle2", wbif.wb_ack_o, 0);
        @(negedge clk);
        check("t5_ack_cycle3", wbif.wb_ack_o, 1);
        @(negedge clk);
        check("t5_ack_cycle4", wbif.wb_ack_o, 0);
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_stb_i = 1'b0;
        @(negedge clk);
        wb_xfer(1'b1, 2'd3, 8'hFF, rd);
        wb_xfer(1'b0, 2'd3, 8'h00, rd);
        check("t5_level_ro", rd, 8'hA5);
        wb_xfer(1'b0, 2'd0, 8'h00, rd);
        check("t5_pend_quiet", rd, 8'h00);

        // Reset while pin 2 has two disagreeing samples counted.
        rst_n = 1'b0;
        pads  = 8'h04;
        repeat (2) @(negedge clk);
        check_reset_state("t6_reset");
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (gpio_clean[2]) seen = 1'b1;
        end
        check("t6_count_restarted", seen, 0);
        @(negedge clk);
        check("t6_fresh_toggle", gpio_clean[2], 1);
        check("t6_irq_quiet", irq, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
